// File: rtl/apb_master.sv
// APB master bridging a valid/ready request channel to a single APB transfer.
// Optional ACCESS-phase timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be within 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d  = ST_SETUP;
                    pwrite_d = req_write_i;
                    paddr_d  = req_addr_i;
                    pwdata_d = req_wdata_i;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = CNT_W'(1);
`endif
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = pslverr_i;
                    rsp_rdata_d = pwrite_q ? 32'h0 : prdata_i;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // Terminal count without pready aborts with an error response
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Control outputs are registered copies of the next-state decode
        req_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ready_o = req_ready_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort; legal range 1..255.
REQ-002 SHALL have ports clk_i input 1 clock; rst_i input 1 reset, synchronous, active-high.
REQ-003 SHALL have req_valid_i input 1 request present; req_ready_o output 1 request accepted when both high at posedge.
REQ-004 SHALL have req_addr_i input 32, req_write_i input 1 (1=write), req_wdata_i input 32 write data.
REQ-005 SHALL have rsp_valid_o output 1, rsp_ready_i input 1, rsp_rdata_o output 32, rsp_err_o output 1 response channel.
REQ-006 SHALL have APB ports psel_o, penable_o, pwrite_o outputs 1; paddr_o, pwdata_o outputs 32.
REQ-007 SHALL have APB ports prdata_i input 32, pready_i input 1, pslverr_i input 1.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only.
REQ-009 SHALL drive req_ready_o=1 only in IDLE; handshake in IDLE latches addr/write/wdata and moves to SETUP.
REQ-010 SHALL in SETUP drive psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o = latched values; next state ACCESS unconditionally.
REQ-011 SHALL in ACCESS drive psel_o=1, penable_o=1, address/control/data unchanged from SETUP.
REQ-012 SHALL stay in ACCESS while pready_i=0; on posedge with pready_i=1 move to RESP.
REQ-013 SHALL on completion capture rsp_err_o=pslverr_i; rsp_rdata_o=prdata_i for reads, 0 for writes.
REQ-014 SHALL drive psel_o=0, penable_o=0 in IDLE and RESP; paddr_o/pwrite_o/pwdata_o hold last values outside transfers.
REQ-015 SHALL in RESP drive rsp_valid_o=1 holding rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1 at posedge, then go IDLE.
REQ-016 SHALL give zero-wait-state latency: accept edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid_o high N+3; next accept earliest at N+4 edge (rsp_ready_i held high).
REQ-017 SHALL ignore pready_i, pslverr_i, prdata_i outside ACCESS.
REQ-018 SHALL ignore req_valid_i outside IDLE; request fields need only be stable at handshake edge.
REQ-019 SHALL never assert penable_o without psel_o, and SHALL deassert penable_o the cycle after completion.

Reset
REQ-020 SHALL on rst_i=1 at posedge enter IDLE and clear psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout counter.
REQ-021 SHALL abandon any in-flight transfer on reset mid-operation (SETUP/ACCESS/RESP) without emitting a response.
REQ-022 SHALL drive req_ready_o=1 in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL compile ACCESS timeout only when macro APB_MASTER_TIMEOUT_EN is defined.
REQ-024 SHALL with APB_MASTER_TIMEOUT_EN count ACCESS cycles from 1; if count reaches TIMEOUT_CYCLES with pready_i=0, go RESP with rsp_err_o=1, rsp_rdata_o=0, psel_o/penable_o dropped.
REQ-025 SHALL with APB_MASTER_TIMEOUT_EN let pready_i=1 in the terminal count cycle win (normal completion, rsp_err_o=pslverr_i).
REQ-026 SHALL without APB_MASTER_TIMEOUT_EN wait in ACCESS indefinitely; TIMEOUT_CYCLES unused, no counter logic.

Verification
REQ-027 Write addr 32'h0000_1000 data 32'h1234_5678, pready_i=1 -> SETUP then one ACCESS cycle with those values, rsp_valid_o at N+3, rsp_err_o=0, rsp_rdata_o=0.
REQ-028 Read addr 32'h2000_3000, prdata_i=32'hCAFE_BEE2, pready_i low 3 ACCESS cycles -> psel/penable held 4 ACCESS cycles, rsp_rdata_o=32'hCAFE_BEE2.
REQ-029 Read with pslverr_i=1 at completion -> rsp_err_o=1; rsp_ready_i held low 5 cycles -> rsp_valid_o/data stable, req_ready_o=0 throughout.
REQ-030 Back-to-back writes 32'h6000_00F0 (32'h55AA_AA55 then 32'h5555), req_valid_i and rsp_ready_i held high -> accepts 4 cycles apart, never penable_o without psel_o.
REQ-031 rst_i pulsed during ACCESS -> next cycle all outputs zero, req_ready_o=1, no rsp_valid_o.
REQ-032 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready_i stuck 0 -> exactly 4 ACCESS cycles, then rsp_err_o=1, rsp_rdata_o=0.
